// File: rtl/lc3_probe_checker.sv
// Per-cycle comparator of LC3 DUT probe channels against golden-reference values.
// Mismatching cycles are logged into a show-ahead error FIFO; per-channel and global statistics are kept alongside.
module lc3_probe_checker #(
    parameter int NCH         = 4,
    parameter int DW          = 16,
    parameter int DEPTH       = 8,
    parameter int CNT_W       = 8,
    parameter bit STOP_ON_ERR = 1'b0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   clear,
    input  logic [NCH-1:0]         chan_mask,
    input  logic [NCH-1:0]         sample_valid,
    input  logic [NCH*DW-1:0]      dut_val,
    input  logic [NCH*DW-1:0]      ref_val,
    input  logic [15:0]            tag,
    input  logic                   err_pop,
    output logic                   err_valid,
    output logic [NCH-1:0]         err_mask,
    output logic [15:0]            err_tag,
    output logic [15:0]            err_time,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic                   overflow,
    output logic                   halted,
    output logic [NCH*CNT_W-1:0]   chan_err_cnt,
    output logic [31:0]            compare_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = NCH + 32;

    logic [NCH-1:0]   cmp_vec;
    logic [NCH-1:0]   mis_vec;
    logic [NCH-1:0]   s1_vec;
    logic [15:0]      s1_tag;
    logic [15:0]      s1_time;
    logic [15:0]      tstamp;
    logic [CNT_W-1:0] cnt [NCH];
    logic [EW-1:0]    mem [DEPTH];
    logic [EW-1:0]    head;
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      level;
    logic             push_req;
    logic             pop_ok;
    logic             full;
    logic             do_push;
    logic             drop;

    always_comb begin
        cmp_vec = '0;
        mis_vec = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            cmp_vec[i] = enable & chan_mask[i] & sample_valid[i] & ~halted;
            mis_vec[i] = cmp_vec[i] & (dut_val[i*DW +: DW] != ref_val[i*DW +: DW]);
        end
    end

    // Once halted, entries still in stage 1 are discarded so the freeze leaves a single logged entry.
    assign level    = wr_ptr - rd_ptr;
    assign full     = (level == (AW+1)'(DEPTH));
    assign pop_ok   = err_pop & err_valid;
    assign push_req = (s1_vec != '0) & ~halted;
    assign do_push  = push_req & (~full | pop_ok);
    assign drop     = push_req & full & ~pop_ok;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tstamp        <= '0;
            s1_vec        <= '0;
            s1_tag        <= '0;
            s1_time       <= '0;
            compare_count <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            overflow      <= 1'b0;
            halted        <= 1'b0;
            for (int unsigned i = 0; i < NCH; i++) cnt[i] <= '0;
        end else if (clear) begin
            tstamp        <= '0;
            s1_vec        <= '0;
            s1_tag        <= '0;
            s1_time       <= '0;
            compare_count <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            overflow      <= 1'b0;
            halted        <= 1'b0;
            for (int unsigned i = 0; i < NCH; i++) cnt[i] <= '0;
        end else begin
            if (enable && !halted) tstamp <= tstamp + 16'd1;
            s1_vec  <= mis_vec;
            s1_tag  <= tag;
            s1_time <= tstamp;
            if (cmp_vec != '0) compare_count <= compare_count + 32'd1;
            for (int unsigned i = 0; i < NCH; i++) begin
                if (mis_vec[i] && (cnt[i] != '1)) cnt[i] <= cnt[i] + 1'b1;
            end
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            if (drop)    overflow <= 1'b1;
            if (STOP_ON_ERR && push_req) halted <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= {s1_vec, s1_tag, s1_time};
    end

    assign head       = mem[rd_ptr[AW-1:0]];
    assign err_valid  = (level != '0);
    assign err_mask   = err_valid ? head[EW-1:32] : '0;
    assign err_tag    = err_valid ? head[31:16]   : '0;
    assign err_time   = err_valid ? head[15:0]    : '0;
    assign fifo_level = level;

    always_comb begin
        chan_err_cnt = '0;
        for (int unsigned i = 0; i < NCH; i++) chan_err_cnt[i*CNT_W +: CNT_W] = cnt[i];
    end

endmodule

// File: tb/tb_lc3_probe_checker.sv
// Directed bench for lc3_probe_checker: one free-running instance and one with STOP_ON_ERR set.
module tb_lc3_probe_checker;

    logic        clock;
    logic        reset;
    logic        enable;
    logic        clear;
    logic [3:0]  chan_mask;
    logic [3:0]  sample_valid;
    logic [63:0] dut_val;
    logic [63:0] ref_val;
    logic [15:0] tag;
    logic        err_pop;

    logic        err_valid,  h_err_valid;
    logic [3:0]  err_mask,   h_err_mask;
    logic [15:0] err_tag,    h_err_tag;
    logic [15:0] err_time,   h_err_time;
    logic [3:0]  fifo_level, h_fifo_level;
    logic        overflow,   h_overflow;
    logic        halted,     h_halted;
    logic [31:0] chan_err_cnt, h_chan_err_cnt;
    logic [31:0] compare_count, h_compare_count;

    int n_checks = 0;
    int n_errors = 0;

    lc3_probe_checker #(.NCH(4), .DW(16), .DEPTH(8), .CNT_W(8), .STOP_ON_ERR(1'b0)) u_dut (
        .clock(clock), .reset(reset), .enable(enable), .clear(clear),
        .chan_mask(chan_mask), .sample_valid(sample_valid),
        .dut_val(dut_val), .ref_val(ref_val), .tag(tag), .err_pop(err_pop),
        .err_valid(err_valid), .err_mask(err_mask), .err_tag(err_tag), .err_time(err_time),
        .fifo_level(fifo_level), .overflow(overflow), .halted(halted),
        .chan_err_cnt(chan_err_cnt), .compare_count(compare_count)
    );

    lc3_probe_checker #(.NCH(4), .DW(16), .DEPTH(8), .CNT_W(8), .STOP_ON_ERR(1'b1)) u_halt (
        .clock(clock), .reset(reset), .enable(enable), .clear(clear),
        .chan_mask(chan_mask), .sample_valid(sample_valid),
        .dut_val(dut_val), .ref_val(ref_val), .tag(tag), .err_pop(err_pop),
        .err_valid(h_err_valid), .err_mask(h_err_mask), .err_tag(h_err_tag), .err_time(h_err_time),
        .fifo_level(h_fifo_level), .overflow(h_overflow), .halted(h_halted),
        .chan_err_cnt(h_chan_err_cnt), .compare_count(h_compare_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            @(negedge clock);
        end
    endtask

    // Random per-channel data; channels set in mis get ref differing from dut.
    task automatic drive(input logic [3:0] mis);
        for (int i = 0; i < 4; i++) begin
            logic [15:0] r;
            r = 16'($urandom);
            dut_val[i*16 +: 16] = r;
            ref_val[i*16 +: 16] = mis[i] ? (r ^ 16'h0001) : r;
        end
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; clear = 1'b0; chan_mask = '0; sample_valid = '0;
        dut_val = '0; ref_val = '0; tag = '0; err_pop = 1'b0;
        #1 reset = 1'b0;

        // Reset held with random stimulus
        repeat (3) begin
            enable = 1'($urandom); chan_mask = 4'($urandom); sample_valid = 4'($urandom);
            dut_val = {$urandom, $urandom}; ref_val = {$urandom, $urandom};
            tag = 16'($urandom); err_pop = 1'($urandom);
            tick(1);
        end
        check("rst_valid", 32'(err_valid), 0);
        check("rst_level", 32'(fifo_level), 0);
        check("rst_ccount", compare_count, 0);
        check("rst_cnt", chan_err_cnt, 0);
        check("rst_ovf_halt", {30'd0, overflow, h_halted}, 0);
        check("rst_head", {err_mask, err_tag, err_time[11:0]}, 0);

        enable = 1'b0; chan_mask = '0; sample_valid = '0; err_pop = 1'b0; tag = '0;
        dut_val = '0; ref_val = '0;
        reset = 1'b1;
        tick(1);

        // Clean run
        enable = 1'b1; chan_mask = 4'hF; sample_valid = 4'hF;
        for (int c = 0; c < 10; c++) begin
            drive(4'h0);
            tick(1);
        end
        check("clean_ccount", compare_count, 10);
        check("clean_valid", 32'(err_valid), 0);
        check("clean_cnt", chan_err_cnt, 0);

        // Single mismatch sampled at timestamp 5
        do_clear();
        for (int c = 0; c < 5; c++) begin
            drive(4'h0);
            tick(1);
        end
        drive(4'h0);
        dut_val[47:32] = 16'h1234; ref_val[47:32] = 16'h1235; tag = 16'h3000;
        tick(1);
        drive(4'h0); tag = 16'h0000;
        check("single_latency", 32'(err_valid), 0);
        tick(1);
        check("single_valid", 32'(err_valid), 1);
        check("single_mask", 32'(err_mask), 32'h4);
        check("single_tag", 32'(err_tag), 32'h3000);
        check("single_time", 32'(err_time), 5);
        check("single_cnt", chan_err_cnt, 32'h0001_0000);
        err_pop = 1'b1;
        tick(1);
        err_pop = 1'b0;
        check("single_popped", 32'(err_valid), 0);
        err_pop = 1'b1;
        tick(1);
        err_pop = 1'b0;
        check("pop_empty_level", 32'(fifo_level), 0);

        // Multi-channel with a masked channel and an invalid channel
        do_clear();
        chan_mask = 4'b1101; sample_valid = 4'b1011; tag = 16'hABCD;
        drive(4'b1111);
        tick(1);
        chan_mask = 4'hF; sample_valid = 4'hF; drive(4'h0);
        tick(1);
        check("multi_level", 32'(fifo_level), 1);
        check("multi_mask", 32'(err_mask), 32'h9);
        check("multi_tag", 32'(err_tag), 32'hABCD);
        check("multi_cnt", chan_err_cnt, 32'h0100_0001);

        // Overflow and ordering
        do_clear();
        for (int c = 0; c < 10; c++) begin
            drive(4'b0001); tag = 16'(c);
            tick(1);
        end
        drive(4'h0);
        tick(1);
        check("ovf_level", 32'(fifo_level), 8);
        check("ovf_flag", 32'(overflow), 1);
        check("ovf_cnt", chan_err_cnt, 32'h0000_000A);
        for (int c = 0; c < 8; c++) begin
            check($sformatf("order_tag%0d", c), 32'(err_tag), 32'(c));
            err_pop = 1'b1;
            tick(1);
            err_pop = 1'b0;
        end
        check("order_empty", 32'(err_valid), 0);

        // Push and pop together while full
        do_clear();
        for (int c = 0; c < 9; c++) begin
            drive(4'b0010); tag = 16'(16'h10 + c);
            tick(1);
        end
        drive(4'h0); err_pop = 1'b1;
        tick(1);
        err_pop = 1'b0;
        check("full_pp_level", 32'(fifo_level), 8);
        check("full_pp_ovf", 32'(overflow), 0);
        check("full_pp_head", 32'(err_tag), 32'h11);

        // Halt on first error, then clear
        do_clear();
        tag = 16'h0;
        for (int c = 0; c < 3; c++) begin
            drive(4'h0);
            tick(1);
        end
        drive(4'b0001); tag = 16'h0303;
        tick(1);
        drive(4'b0001); tag = 16'h0404;
        tick(1);
        drive(4'h0);
        tick(3);
        check("halt_flag", 32'(h_halted), 1);
        check("halt_level", 32'(h_fifo_level), 1);
        check("halt_tag", 32'(h_err_tag), 32'h0303);
        check("halt_time", 32'(h_err_time), 3);
        check("halt_ccount", h_compare_count, 5);
        check("nohalt_flag", 32'(halted), 0);
        do_clear();
        check("clr_halt", 32'(h_halted), 0);
        check("clr_level", 32'(h_fifo_level), 0);
        drive(4'b1000);
        tick(1);
        drive(4'h0);
        tick(2);
        check("resume_level", 32'(h_fifo_level), 1);
        check("resume_ccount", h_compare_count, 2);

        // Reset mid-stream with entries queued and one in flight
        for (int c = 0; c < 3; c++) begin
            drive(4'b0101);
            tick(1);
        end
        #2 reset = 1'b0;
        #1;
        check("midrst_valid", 32'(err_valid), 0);
        check("midrst_level", 32'(fifo_level), 0);
        check("midrst_stats", compare_count | chan_err_cnt, 0);
        check("midrst_halt", 32'(h_halted), 0);
        drive(4'h0);
        @(negedge clock);
        reset = 1'b1;
        tick(2);
        check("midrst_inflight", 32'(err_valid), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/lc3_probe_checker.md
Name: lc3_probe_checker

Overview:
- Parametrised, synthesizable successor to the per-stage golden-reference probe interfaces.
- Compares NCH DUT probe channels (fetch pc/npc, decode IR, execute aluout, writeback VSR, and so on) against golden-reference values every cycle.
- Logs each mismatching cycle into an error FIFO, and keeps per-channel and global statistics.
- Sits beside the LC3 DUT in the bench harness. The testbench drains the FIFO through a pop handshake.

Parameters:
- NCH, 4, number of compared channels (1..16).
- DW, 16, data width per channel.
- DEPTH, 8, error FIFO entries (power of 2, >=2).
- CNT_W, 8, per-channel error counter width (saturating).
- STOP_ON_ERR, 0, 1 = freeze comparison after the first logged mismatch.

Ports:
- clock  in  1  single clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  comparison enable; when low no samples are taken and the timestamp holds.
- clear  in  1  synchronous clear of FIFO, counters, overflow and halted.
- chan_mask  in  NCH  1 = channel participates in comparison.
- sample_valid  in  NCH  per-channel sample strobe.
- dut_val  in  NCH*DW  DUT probe values, channel i at [i*DW +: DW].
- ref_val  in  NCH*DW  golden-reference values, same packing.
- tag  in  16  context tag stored with each error (normally the pc).
- err_pop  in  1  pops the FIFO head.
- err_valid  out  1  FIFO non-empty; head entry is valid.
- err_mask  out  NCH  mismatching channels of the head entry.
- err_tag  out  16  tag of the head entry.
- err_time  out  16  timestamp of the head entry.
- fifo_level  out  $clog2(DEPTH)+1  current occupancy.
- overflow  out  1  sticky; an entry was dropped.
- halted  out  1  STOP_ON_ERR freeze active.
- chan_err_cnt  out  NCH*CNT_W  per-channel mismatch counts.
- compare_count  out  32  number of cycles with at least one compared channel.

Behaviour:
- Reset (reset=0, async): all outputs 0, FIFO empty, timestamp 0. Values are held until reset deasserts; release is synchronised to the next edge.
- Compared channel i at edge k: enable & chan_mask[i] & sample_valid[i] & !halted.
- Mismatch on channel i: compared and dut_val[i] != ref_val[i].
- Stage 1 (edge k): register the mismatch vector, tag and timestamp. Increment compare_count (32-bit wrap) if any channel is compared. Increment chan_err_cnt[i] for each mismatching channel, saturating at 2^CNT_W-1.
- Stage 2 (edge k+1): if the registered vector is nonzero, push one entry {vector, tag, timestamp}.
  - err_valid rises after edge k+1 (show-ahead head).
  - Latency from sample to visible entry: 2 edges.
- Multiple channels mismatching in the same cycle produce one entry with multiple mask bits.
- Timestamp: 16-bit free-running counter, +1 per cycle while enable=1, wraps 0xFFFF -> 0.
- Pop: err_pop & err_valid advances the head at the edge. Pop while empty is ignored; no underflow and level is unchanged.
- Push while full: the entry is dropped, overflow is set sticky, and counters still update.
- Push and pop in the same cycle:
  - When full: both succeed, level stays DEPTH, no overflow.
  - When empty: the push is written and the pop is ignored.
- STOP_ON_ERR=1: halted is set at the edge that pushes the first entry, or that drops it on overflow. Later samples are not compared, the timestamp holds, and the FIFO stays poppable. STOP_ON_ERR=0 never sets halted.
- clear:
  - Empties the FIFO and zeroes the counters, overflow, halted, timestamp and the stage-1 register.
  - Wins over a same-cycle sample, push or pop.
  - Takes effect at the next edge.
- Masked or invalid channels never count and never appear in err_mask.
- chan_mask changes take effect on the next sampled cycle only; entries already registered are unaffected.
- Reset asserted mid-operation: all state is discarded immediately, including entries in flight in stage 1.

Test Plan:
- Reset:
  - Stimulus: NCH=4; hold reset=0, drive random inputs, then release.
  - Required response: all outputs 0, err_valid=0, fifo_level=0.
- Clean run:
  - Stimulus: enable=1, mask=4'hF, all valid, dut=ref for 10 cycles.
  - Required response: compare_count=10, err_valid=0, all chan_err_cnt=0.
- Single mismatch:
  - Stimulus: ch2 dut=0x1234, ref=0x1235, tag=0x3000, sampled at timestamp 5.
  - Required response: err_valid=1 two edges later; err_mask=4'b0100, err_tag=0x3000, err_time=5, chan_err_cnt[2]=1.
  - Then pop: err_valid=0.
- Multi-channel and mask:
  - Stimulus: ch0 and ch3 mismatch, ch1 mismatches but chan_mask[1]=0.
  - Required response: one entry with err_mask=4'b1001; cnt[0]=cnt[3]=1, cnt[1]=0.
- Overflow and ordering:
  - Stimulus: DEPTH=8, 10 consecutive mismatch cycles with tags 0..9, no pops.
  - Required response: fifo_level=8, overflow=1, cnt=10.
  - Then pop 8 times: tags come out 0..7 in order, then err_valid=0.
- Halt and clear:
  - Stimulus: STOP_ON_ERR=1, mismatch at cycle 3 and again at cycle 4.
  - Required response: one entry, halted=1, compare_count stops.
  - Then clear=1 for 1 cycle: halted=0, fifo_level=0, and comparison resumes.
  - Also: reset=0 asserted mid-stream immediately zeroes all outputs.
